instruction_fetch_stage: RTL
============================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage of the RV64 core: owns the PC, drives the instruction-memory address, captures the returned
//  32-bit word into the IF/ID pipeline register. Sits upstream of decode, wraps around the instruction memory.
//  Handles stall, branch redirect, halt detection and end-of-memory.
// PARAMETERS
//  RESET_PC   64'h0             PC value loaded on reset
//  MEM_BYTES  132               instruction-memory size in bytes; last legal fetch at MEM_BYTES-4
//  HALT_INSN  32'h0000_0063     beq x0,x0,0; accepting it into IF/ID halts fetch
// PORTS
//  clk              in   1   single clock, all state on rising edge
//  reset            in   1   synchronous, active-high
//  stall            in   1   hold PC and IF/ID (hazard from decode)
//  branch_taken     in   1   redirect request from execute
//  branch_target    in   64  redirect PC
//  Inst_Address     out  64  byte address to instruction memory (= pc, combinational)
//  Instruction      in   32  word returned combinationally by instruction memory
//  if_id_pc         out  64  PC of the instruction held in IF/ID
//  if_id_instr      out  32  instruction held in IF/ID (NOP 32'h0000_0013 when invalid)
//  if_id_valid      out  1   IF/ID holds a real instruction
//  halted           out  1   fetch has stopped
//  fetch_fault      out  1   misaligned redirect seen (only with FETCH_ALIGN_CHECK_EN; else tied 0)
// BEHAVIOUR
//  - Reset (sync, highest priority): pc=RESET_PC, state=START, if_id_pc=0, if_id_instr=NOP,
//    if_id_valid=0, halted=0, fetch_fault=0. Reset mid-operation discards everything in one edge.
//  - FSM: START -> FETCH (one bubble cycle after reset, IF/ID stays invalid, pc unchanged);
//    FETCH -> HALTED on HALT_INSN captured, or when pc > MEM_BYTES-4; HALTED sticky until reset.
//  - FETCH priority per edge: branch_taken > stall > normal.
//    redirect: pc<=branch_target; IF/ID<=NOP, valid=0 (wrong-path flush); wins over simultaneous stall.
//    stall: pc and IF/ID unchanged.
//    normal: IF/ID<={pc, Instruction, valid=1}; pc<=pc+4 (64-bit, wraps mod 2^64).
//  - Latency: word addressed at cycle n appears on if_id_* at cycle n+1.
//  - End of memory: pc > MEM_BYTES-4 -> no capture, IF/ID<=NOP/invalid, state->HALTED.
//  - HALT_INSN: captured valid into IF/ID, then state->HALTED; pc not advanced further.
//  - HALTED: pc frozen, IF/ID<=NOP/invalid each cycle, halted=1; branch_taken and stall ignored.
//  - branch_taken while stall and halting condition coincide: redirect wins, no halt that cycle.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: redirect with branch_target[1:0]!=0 sets sticky fetch_fault,
//    goes to HALTED, pc keeps old value. Undefined: target low 2 bits forced to 0, fetch_fault tied 0.
// STRUCTURE
//  fetch_pkg: state enum {START, FETCH, HALTED}, NOP_INSN, default HALT_INSN, PC_W=64, INST_W=32.
//  One sub-module: pc_register (pc flop with reset/load/hold/increment controls); FSM and IF/ID in top.
// TESTING
//  1 reset, 3 straight-line words at 0,4,8 -> if_id_pc 0,4,8 on cycles 2,3,4, valid=1 each.
//  2 stall high 2 cycles at pc=8 -> Inst_Address stays 8, if_id_* frozen, resumes with pc=12.
//  3 branch_taken+stall same cycle, target 0x20 -> next pc 0x20, if_id_valid=0, then 0x20 captured.
//  4 HALT_INSN at 0x10 -> if_id_instr=0x63 valid once, then halted=1, valid=0, pc frozen 0x14.
//  5 MEM_BYTES=16, straight run -> after pc=12 captured, pc=16 gives halted=1, no capture.
//  6 FETCH_ALIGN_CHECK_EN, target 0x22 -> fetch_fault=1, halted=1; without macro next pc=0x20.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    // addi x0,x0,0 fills IF/ID whenever it holds no real instruction
    localparam logic [INST_W-1:0] NOP_INSN          = 32'h0000_0013;
    // beq x0,x0,0 is the default end-of-program marker
    localparam logic [INST_W-1:0] DEFAULT_HALT_INSN = 32'h0000_0063;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter register: reset to a fixed value, load a redirect target,
// advance by one instruction word, or hold.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // next pc: load beats increment; otherwise hold
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + 64'd4;
        end
    end

    // pc state, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the pc, addresses instruction memory and fills the IF/ID register.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirects fault and halt fetch;
// when undefined the redirect target is word-aligned and fetch_fault is tied low).
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC  = 64'h0,
    parameter int                MEM_BYTES = 132,
    parameter logic [INST_W-1:0] HALT_INSN = DEFAULT_HALT_INSN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    output logic [PC_W-1:0]   Inst_Address,
    input  logic [INST_W-1:0] Instruction,
    output logic [PC_W-1:0]   if_id_pc,
    output logic [INST_W-1:0] if_id_instr,
    output logic              if_id_valid,
    output logic              halted,
    output logic              fetch_fault
);

    // highest byte address at which a whole word can still be fetched
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_BYTES - 4);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   if_id_pc_q, if_id_pc_d;
    logic [INST_W-1:0] if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic              fault_q, fault_d;

    logic [PC_W-1:0]   pc;
    logic              pc_load;
    logic              pc_inc;
    logic [PC_W-1:0]   pc_load_val;
    logic              target_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_misaligned = (branch_target[1:0] != 2'b00);
`else
    assign target_misaligned = 1'b0;
`endif

    // redirect targets are always word aligned when they reach the pc
    assign pc_load_val = branch_target & ~64'h3;

    pc_register #(
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (pc_load_val),
        .pc       (pc)
    );

    // next-state, IF/ID update and pc control; redirect > stall > end-of-memory > capture
    always_comb begin
        state_d       = state_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        fault_d       = fault_q;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;

        unique case (state_q)
            ST_START: begin
                // one bubble cycle after reset before the first capture
                state_d       = ST_FETCH;
                if_id_pc_d    = '0;
                if_id_instr_d = NOP_INSN;
                if_id_valid_d = 1'b0;
            end
            ST_FETCH: begin
                if (branch_taken) begin
                    // wrong-path flush; a bad target keeps the old pc and stops fetch
                    if_id_pc_d    = '0;
                    if_id_instr_d = NOP_INSN;
                    if_id_valid_d = 1'b0;
                    if (target_misaligned) begin
                        fault_d = 1'b1;
                        state_d = ST_HALTED;
                    end else begin
                        pc_load = 1'b1;
                    end
                end else if (stall) begin
                    // hold pc and IF/ID
                end else if (pc > LAST_PC) begin
                    if_id_pc_d    = '0;
                    if_id_instr_d = NOP_INSN;
                    if_id_valid_d = 1'b0;
                    state_d       = ST_HALTED;
                end else begin
                    if_id_pc_d    = pc;
                    if_id_instr_d = Instruction;
                    if_id_valid_d = 1'b1;
                    pc_inc        = 1'b1;
                    if (Instruction == HALT_INSN) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            default: begin
                // halted: pc frozen, IF/ID drained to a bubble every cycle
                if_id_pc_d    = '0;
                if_id_instr_d = NOP_INSN;
                if_id_valid_d = 1'b0;
            end
        endcase
    end

    // state and IF/ID registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_START;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSN;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // sticky misaligned-redirect flag
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fetch_fault = fault_q;
`else
    assign fault_q     = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign Inst_Address = pc;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_valid  = if_id_valid_q;
    assign halted       = (state_q == ST_HALTED);

endmodule
